alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, registered W-bit ALU with a valid/ready handshake on both sides.
//  Adds logic ops, shifts, an iterative shift-add multiply and a status-flag set
//  to the two's-complement add/sub datapath.
//  Sits between the CPU decode stage (producer) and register writeback (consumer).
//  Holds one operation in flight at a time.
// PARAMETERS
//  W     8          operand/result width in bits, >= 2
//  SHW   $clog2(W)  localparam: shift-amount width, taken from b[SHW-1:0]
// PORTS
//  clk        in   1  rising-edge clock, single clock domain
//  rst_n      in   1  asynchronous reset, active low
//  in_valid   in   1  op/a/b are valid
//  in_ready   out  1  block accepts an op this cycle
//  op         in   3  opcode (see BEHAVIOUR)
//  a, b       in   W  operands
//  out_valid  out  1  res and flags are valid
//  out_ready  in   1  consumer takes the result this cycle
//  res        out  W  result
//  carry      out  1  carry / no-borrow / shifted-out bit / mul high-half-nonzero
//  zero       out  1  res == 0
//  neg        out  1  res[W-1]
//  ovf        out  1  signed overflow, ADD/SUB only; otherwise 0
//  err        out  1  unsupported op
// BEHAVIOUR
//  - Opcodes:
//    - 000 ADD: {carry,res} = a+b
//    - 001 SUB: {carry,res} = a+~b+1, so carry=1 iff a>=b unsigned
//    - 010 AND, 011 OR, 100 XOR: carry=0
//    - 101 SHL, 110 SHR (logical): shift by b[SHW-1:0]
//      - carry = last bit shifted out; shift of 0 -> res=a, carry=0
//    - 111 MUL: res = low W bits of a*b (unsigned); carry = |high W bits
//  - ovf (ADD/SUB): a, b' same sign and res sign differs, where b' is b for ADD, ~b for SUB.
//  - zero and neg are derived from res for every op.
//  - FSM states: IDLE, MUL, HOLD.
//  - in_ready = (state==IDLE) | (state==HOLD & out_ready). Combinational, no
//    dependence on in_valid.
//  - Accept = in_valid & in_ready.
//    - Non-MUL op: result and flags registered at the accept edge -> HOLD,
//      out_valid=1 from the next cycle (latency 1).
//    - MUL op: operands latched -> MUL state, one shift-add step per clock for
//      W clocks, then res/flags written and -> HOLD. out_valid rises exactly W
//      edges after the accept edge. in_ready=0 throughout MUL.
//  - HOLD: res/flags/out_valid held stable while out_ready=0.
//    - out_ready=1 with no accept -> IDLE, out_valid=0 next cycle.
//    - out_ready=1 with accept (back-to-back) -> new op processed as from IDLE,
//      with no bubble for non-MUL ops.
//  - out_ready is ignored while out_valid=0. in_valid is ignored while in_ready=0.
//  - Reset (rst_n low, any time including mid-MUL):
//    - state=IDLE, out_valid=0, res=0, all flags=0, MUL progress discarded.
//    - in_ready=1 from the first cycle after release.
// CONFIGURATION
//  - ALU_MUL_EN defined: MUL supported as above; err is constant 0.
//  - ALU_MUL_EN undefined: no MUL state or multiplier datapath.
//    - op 111 completes in 1 cycle like a logic op: res=0, carry=ovf=neg=0,
//      zero=1, err=1.
//    - err=0 for all other ops.
// TESTING (W=8 unless noted)
//  1. SUB a=3 b=2, out_ready=1 -> res=0x01 carry=1 zero=0 ovf=0, out_valid 1 cycle after accept
//  2. ADD 0xFF+0x01 -> res=0x00 carry=1 zero=1. ADD 0x7F+0x01 -> res=0x80 ovf=1 neg=1 carry=0
//  3. ADD 1+1, hold out_ready=0 for 5 cycles -> res=0x02 stable, in_ready=0; then out_ready=1 with in_valid=1 (XOR 0xF0,0xFF) -> accepted that cycle, res=0x0F next cycle
//  4. MUL 13*11 -> res=0x8F carry=0, out_valid exactly 8 edges after accept, in_ready=0 meanwhile; MUL 16*16 -> res=0x00 carry=1 zero=1
//  5. MUL started, rst_n low at cycle 4 of MUL -> out_valid=0, res=0 immediately; after release in_ready=1 and ADD 2+2 -> res=0x04 normally
//  6. SHL 0x81 by 1 -> res=0x02 carry=1; SHR 0x81 by 0 -> res=0x81 carry=0; ALU_MUL_EN undefined: op=111 -> res=0 err=1 zero=1, latency 1

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered W-bit ALU with valid/ready handshake; ALU_MUL_EN enables iterative MUL
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         carry,
  output logic         zero,
  output logic         neg,
  output logic         ovf,
  output logic         err
);

  localparam int SHW = $clog2(W);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_MUL_EN
    S_MUL  = 2'd1,
`endif
    S_HOLD = 2'd2
  } state_t;

  state_t         state_q;
  logic           out_valid_q;
  logic [W-1:0]   res_q;
  logic           carry_q;
  logic           zero_q;
  logic           neg_q;
  logic           ovf_q;
  logic           err_q;

  logic           accept;
  logic [W-1:0]   res_d;
  logic           carry_d;
  logic           ovf_d;
  logic           err_d;
  logic           is_sub;
  logic [W-1:0]   b_eff;
  logic [W:0]     sum_w;
  logic [W:0]     shl_w;
  logic [W:0]     shr_w;
  logic [SHW-1:0] sh_amt;

`ifdef ALU_MUL_EN
  localparam logic [SHW-1:0] CNT_LAST = SHW'(W - 1);

  logic [2*W-1:0] mcand_q;
  logic [2*W-1:0] acc_q;
  logic [W-1:0]   mplier_q;
  logic [SHW-1:0] cnt_q;
  logic [2*W-1:0] acc_next;

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

  // Single-cycle result for every op except an enabled MUL
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    is_sub  = (op == OP_SUB);
    b_eff   = is_sub ? ~b : b;
    sum_w   = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, is_sub};
    sh_amt  = b[SHW-1:0];
    // Extra bit on the far side of each shifter catches the last bit shifted out
    shl_w   = {1'b0, a} << sh_amt;
    shr_w   = {a, 1'b0} >> sh_amt;
    case (op)
      OP_ADD, OP_SUB: begin
        res_d   = sum_w[W-1:0];
        carry_d = sum_w[W];
        ovf_d   = (a[W-1] == b_eff[W-1]) & (sum_w[W-1] != a[W-1]);
      end
      OP_AND: res_d = a & b;
      OP_OR:  res_d = a | b;
      OP_XOR: res_d = a ^ b;
      OP_SHL: begin
        res_d   = shl_w[W-1:0];
        carry_d = shl_w[W];
      end
      OP_SHR: begin
        res_d   = shr_w[W:1];
        carry_d = shr_w[0];
      end
      default: begin
`ifdef ALU_MUL_EN
        res_d = '0;
`else
        err_d = 1'b1;
`endif
      end
    endcase
  end

  // Control FSM plus registered result/flags and multiplier datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
`ifdef ALU_MUL_EN
        S_MUL: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == CNT_LAST) begin
            state_q     <= S_HOLD;
            out_valid_q <= 1'b1;
            res_q       <= acc_next[W-1:0];
            carry_q     <= |acc_next[2*W-1:W];
            zero_q      <= (acc_next[W-1:0] == '0);
            neg_q       <= acc_next[W-1];
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q + SHW'(1);
          end
        end
`endif
        default: begin
          // IDLE and HOLD accept identically, so back-to-back ops need no bubble
          if (accept) begin
`ifdef ALU_MUL_EN
            if (op == OP_MUL) begin
              state_q     <= S_MUL;
              out_valid_q <= 1'b0;
              mcand_q     <= {{W{1'b0}}, a};
              mplier_q    <= b;
              acc_q       <= '0;
              cnt_q       <= '0;
            end else
`endif
            begin
              state_q     <= S_HOLD;
              out_valid_q <= 1'b1;
              res_q       <= res_d;
              carry_q     <= carry_d;
              zero_q      <= (res_d == '0);
              neg_q       <= res_d[W-1];
              ovf_q       <= ovf_d;
              err_q       <= err_d;
            end
          end else if ((state_q == S_HOLD) && out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a behavioural reference model
module tb_alu_seq;

  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         carry;
  logic         zero;
  logic         neg;
  logic         ovf;
  logic         err;

  int n_vec;
  int n_err;

  logic         m_valid;
  int           m_busy;
  logic [W+4:0] m_cur;
  logic [W+4:0] m_pend;
  logic         m_rdy;

  alu_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .carry     (carry),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result: {res, carry, zero, neg, ovf, err} from plain integer arithmetic
  function automatic logic [W+4:0] golden(input logic [2:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    longint ux, uy, sx, sy, r, s, lim;
    int n;
    logic [W-1:0] rr;
    logic c, v, e;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y);
    lim = longint'(1) << (W - 1);
    n = int'(uy % W);
    rr = '0; c = 1'b0; v = 1'b0; e = 1'b0; r = 0; s = 0;
    case (o)
      3'd0: begin
        r = ux + uy; rr = r[W-1:0]; c = ((r >> W) != 0);
        s = sx + sy; v = (s >= lim) || (s < -lim);
      end
      3'd1: begin
        r = ux - uy; rr = r[W-1:0]; c = (ux >= uy);
        s = sx - sy; v = (s >= lim) || (s < -lim);
      end
      3'd2: rr = x & y;
      3'd3: rr = x | y;
      3'd4: rr = x ^ y;
      3'd5: begin
        if (n != 0) begin r = ux << n; rr = r[W-1:0]; c = ux[W-n]; end
        else rr = x;
      end
      3'd6: begin
        if (n != 0) begin r = ux >> n; rr = r[W-1:0]; c = ux[n-1]; end
        else rr = x;
      end
      default: begin
        if (MUL_EN) begin r = ux * uy; rr = r[W-1:0]; c = ((r >> W) != 0); end
        else e = 1'b1;
      end
    endcase
    return {rr, c, (rr == '0), rr[W-1], v, e};
  endfunction

  // Transaction-level model: pending result, remaining MUL clocks, whether one is on offer
  assign m_rdy = (m_busy == 0) && (!m_valid || out_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_busy  <= 0;
      m_cur   <= '0;
      m_pend  <= '0;
    end else if (in_valid && m_rdy) begin
      if (op == 3'b111 && MUL_EN) begin
        m_busy  <= W;
        m_valid <= 1'b0;
        m_pend  <= golden(op, a, b);
      end else begin
        m_valid <= 1'b1;
        m_cur   <= golden(op, a, b);
      end
    end else if (m_busy != 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_valid <= 1'b1;
        m_cur   <= m_pend;
      end
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {18'd0, out_valid, res, carry, zero, neg, ovf, err};
  endfunction

  function automatic logic [31:0] pk(input logic v, input logic [7:0] r, input logic c,
                                     input logic z, input logic n, input logic o,
                                     input logic e);
    return {18'd0, v, r, c, z, n, o, e};
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_outputs", outs(), 32'd0);
      end else begin
        check("model_in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
        check("model_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid)
          check("model_result", {19'd0, res, carry, zero, neg, ovf, err}, {19'd0, m_cur});
      end
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int waited);
    bit got;
    in_valid = 1'b1; op = o; a = x; b = y;
    waited = 0; got = 1'b0;
    while (!got && waited < 50) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else waited++;
    end
    if (!got) check("issue_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_lit(input string nm, input logic [31:0] exp);
    @(negedge clk);
    check(nm, outs(), exp);
  endtask

  task automatic run_vec(input string nm, input logic [2:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic [31:0] exp);
    int w;
    sync();
    issue(o, x, y, w);
    check({nm, "_wait"}, w, 32'd0);
    check_lit(nm, exp);
  endtask

  initial begin
    int w;
    int cnt;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0;
    fork
      monitor();
    join_none

    #2 check("reset_state", outs(), pk(0, 8'h00, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Basic arithmetic with out_ready held high
    run_vec("t1_sub_3_2",   3'b001, 8'h03, 8'h02, pk(1, 8'h01, 1, 0, 0, 0, 0));
    run_vec("t2_add_ff_01", 3'b000, 8'hFF, 8'h01, pk(1, 8'h00, 1, 1, 0, 0, 0));
    run_vec("t2_add_7f_01", 3'b000, 8'h7F, 8'h01, pk(1, 8'h80, 0, 0, 1, 1, 0));

    // Consumer stall then back-to-back accept on the release cycle
    sync();
    out_ready = 1'b0;
    issue(3'b000, 8'h01, 8'h01, w);
    check_lit("t3_add_1_1", pk(1, 8'h02, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_res", outs(), pk(1, 8'h02, 0, 0, 0, 0, 0));
      check("t3_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    sync();
    out_ready = 1'b1;
    issue(3'b100, 8'hF0, 8'hFF, w);
    check("t3_b2b_wait", w, 32'd0);
    check_lit("t3_xor", pk(1, 8'h0F, 0, 0, 0, 0, 0));

`ifdef ALU_MUL_EN
    // Iterative multiply: latency of exactly W edges after accept
    sync();
    issue(3'b111, 8'd13, 8'd11, w);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 40);
    check("t4_mul_latency", cnt, W);
    check("t4_mul_13_11", outs(), pk(1, 8'h8F, 0, 0, 1, 0, 0));
    sync();
    issue(3'b111, 8'd16, 8'd16, w);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 40);
    check("t4_mul_latency2", cnt, W);
    check("t4_mul_16_16", outs(), pk(1, 8'h00, 1, 1, 0, 0, 0));

    // Reset in the middle of a multiply
    sync();
    issue(3'b111, 8'd13, 8'd11, w);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
`else
    // Reset while a result is being held
    sync();
    out_ready = 1'b0;
    issue(3'b000, 8'd5, 8'd5, w);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
`endif
    #1 check("t5_async_reset", outs(), pk(0, 8'h00, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_ready_after_release", {31'd0, in_ready}, 32'd1);
    run_vec("t5_add_2_2", 3'b000, 8'h02, 8'h02, pk(1, 8'h04, 0, 0, 0, 0, 0));

    // Shifts and boundary vectors
    run_vec("t6_shl_81_1",  3'b101, 8'h81, 8'h01, pk(1, 8'h02, 1, 0, 0, 0, 0));
    run_vec("t6_shr_81_0",  3'b110, 8'h81, 8'h00, pk(1, 8'h81, 0, 0, 1, 0, 0));
    run_vec("shr_81_1",     3'b110, 8'h81, 8'h01, pk(1, 8'h40, 1, 0, 0, 0, 0));
    run_vec("shl_81_f",     3'b101, 8'h81, 8'h0F, pk(1, 8'h80, 0, 0, 1, 0, 0));
    run_vec("and_f0_3c",    3'b010, 8'hF0, 8'h3C, pk(1, 8'h30, 0, 0, 0, 0, 0));
    run_vec("or_f0_0f",     3'b011, 8'hF0, 8'h0F, pk(1, 8'hFF, 0, 0, 1, 0, 0));
    run_vec("xor_aa_aa",    3'b100, 8'hAA, 8'hAA, pk(1, 8'h00, 0, 1, 0, 0, 0));
    run_vec("sub_00_01",    3'b001, 8'h00, 8'h01, pk(1, 8'hFF, 0, 0, 1, 0, 0));
    run_vec("sub_80_01",    3'b001, 8'h80, 8'h01, pk(1, 8'h7F, 1, 0, 0, 1, 0));
    run_vec("add_80_80",    3'b000, 8'h80, 8'h80, pk(1, 8'h00, 1, 1, 0, 1, 0));
`ifndef ALU_MUL_EN
    run_vec("t6_op111_err", 3'b111, 8'h12, 8'h34, pk(1, 8'h00, 0, 1, 0, 0, 1));
`endif

    sync();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
